btn_event_gen: RTL and testbench

Converts the debounced, active-low button levels of the front panel into discrete key events: press, release, long-press and auto-repeat. Events are tagged with a button index and queued in a small FIFO. A valid/ready handshake presents them to the game-control logic. The block sits directly downstream of the per-button debouncers, on the same clock.

---
 rtl/btn_event_pkg.sv | 28 ++
 rtl/btn_event_gen_fifo.sv | 65 ++++++
 rtl/btn_event_gen.sv | 206 ++++++++++++++++++++
 tb/tb_btn_event_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event generator.
//   - Event kind codes carried on evt_kind.
//   - Per-button FSM state encoding.
//   - Small constant helpers used to size counters and indices.
package btn_event_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width with a floor of one bit, so a single-button build still
    // has a legal evt_btn port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_gen_fifo.sv
// evt_fifo: first-word-fall-through queue for tagged key events.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wdata: write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : remove the head entry; ignored while empty
//   rdata      : head entry, valid whenever empty is low
//   full, empty: occupancy flags
// Storage is cleared by reset so the head reads as zero out of reset.
module evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // Full-and-popping frees the head slot in the same edge, so the write
    // can land without exceeding the depth.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced active-low button levels into key events
// (PRESS, RELEASE, LONG, REPEAT) tagged with the button index and queued
// for the game-control logic.
//   clk, rst_n : clock, asynchronous active-low reset
//   btns       : debounced button levels, 0 = pressed
//   evt_valid  : an event is at the queue head
//   evt_ready  : consumer takes the head event
//   evt_btn    : button index of the head event
//   evt_kind   : 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   overflow   : sticky, set when an event is dropped; cleared by reset
//
// Handshake: the head event transfers on every clock edge where evt_valid
// and evt_ready are both high; evt_btn/evt_kind are stable while evt_valid
// is high and not yet accepted, and carry no meaning while it is low.
//
// Each button owns an UP/DOWN/HELD FSM with a cycle counter and a one-entry
// pending slot. A fixed-priority arbiter (lowest index first) moves one
// pending slot per cycle into the FIFO.
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BTNS-1:0]           btns,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [idx_width(NUM_BTNS)-1:0] evt_btn,
    output logic [1:0]                    evt_kind,
    output logic                          overflow
);

    localparam int BTN_W = idx_width(NUM_BTNS);
    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam int EVT_W = BTN_W + 2;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [NUM_BTNS-1:0]      btn_s;
    logic [NUM_BTNS-1:0]      slot_v;
    logic [NUM_BTNS-1:0][1:0] slot_k;
    logic [NUM_BTNS-1:0]      grant;
    logic [NUM_BTNS-1:0]      drain;
    logic [NUM_BTNS-1:0]      drop;

    logic             sel_found;
    logic [BTN_W-1:0] sel_btn;
    logic [1:0]       sel_kind;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EVT_W-1:0] fifo_head;

    // Single register stage on the debounced levels; released after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s <= '1;
        end else begin
            btn_s <= btns;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_state_e       state_q;
        btn_state_e       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             emit;
        logic [1:0]       emit_kind;
        logic             slot_v_q;
        logic [1:0]       slot_k_q;
        logic             slot_free;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_UP;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Release is tested first in DOWN and HELD so it beats a LONG or
        // REPEAT falling due in the same cycle.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            emit      = 1'b0;
            emit_kind = EVT_PRESS;
            case (state_q)
                ST_UP: begin
                    if (!btn_s[i]) begin
                        state_d   = ST_DOWN;
                        cnt_d     = '0;
                        emit      = 1'b1;
                        emit_kind = EVT_PRESS;
                    end
                end
                ST_DOWN: begin
                    if (btn_s[i]) begin
                        state_d   = ST_UP;
                        emit      = 1'b1;
                        emit_kind = EVT_RELEASE;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d   = ST_HELD;
                        cnt_d     = '0;
                        emit      = 1'b1;
                        emit_kind = EVT_LONG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (btn_s[i]) begin
                        state_d   = ST_UP;
                        emit      = 1'b1;
                        emit_kind = EVT_RELEASE;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_d     = '0;
                        emit      = 1'b1;
                        emit_kind = EVT_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end
            endcase
        end

        // A slot being drained this cycle counts as free, so back-to-back
        // events on one button do not overflow while the FIFO keeps up.
        assign slot_free = !slot_v_q || drain[i];
        assign drop[i]   = emit && !slot_free;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_v_q <= 1'b0;
                slot_k_q <= EVT_PRESS;
            end else if (emit && slot_free) begin
                slot_v_q <= 1'b1;
                slot_k_q <= emit_kind;
            end else if (drain[i]) begin
                slot_v_q <= 1'b0;
            end
        end

        assign slot_v[i] = slot_v_q;
        assign slot_k[i] = slot_k_q;
    end

    // Fixed priority: lowest index with a pending event wins.
    always_comb begin
        grant     = '0;
        sel_found = 1'b0;
        sel_btn   = '0;
        sel_kind  = EVT_PRESS;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (slot_v[i] && !sel_found) begin
                grant[i]  = 1'b1;
                sel_found = 1'b1;
                sel_btn   = BTN_W'(i);
                sel_kind  = slot_k[i];
            end
        end
    end

    assign pop     = evt_valid && evt_ready;
    assign push_ok = sel_found && (!fifo_full || pop);
    assign drain   = grant & {NUM_BTNS{push_ok}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .wdata ({sel_btn, sel_kind}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid           = !fifo_empty;
    assign {evt_btn, evt_kind} = fifo_head;

endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;
    import btn_event_pkg::*;

    localparam int NB    = 4;
    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [NB-1:0] btns      = '1;
    logic          evt_ready = 1'b1;
    logic          evt_valid;
    logic [1:0]    evt_btn;
    logic [1:0]    evt_kind;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    btn_event_gen #(
        .NUM_BTNS      (NB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btns      (btns),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_kind  (evt_kind),
        .overflow  (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] ev(input int b, input logic [1:0] k);
        return {2'(b), k};
    endfunction

    // ---------------- reference model ----------------
    // Each button is described by how long it has been pressed (age, -1 when
    // released); event kinds follow directly from the age. exp_q is the
    // expected FIFO content, head first.
    logic [NB-1:0] m_btn_s;
    int            m_age [NB];
    bit            m_sv  [NB];
    logic [1:0]    m_sk  [NB];
    bit            m_ovf;
    logic [3:0]    exp_q [$];

    task automatic model_reset();
        m_btn_s = '1;
        m_ovf   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            m_age[i] = -1;
            m_sv[i]  = 1'b0;
            m_sk[i]  = EVT_PRESS;
        end
    endtask

    task automatic model_step();
        bit         pop;
        bit         push;
        bit         fire;
        int         g;
        logic [1:0] k;
        pop = (exp_q.size() > 0) && evt_ready;
        g = -1;
        for (int i = 0; i < NB; i++) if (m_sv[i] && g < 0) g = i;
        push = (g >= 0) && ((exp_q.size() < DEPTH) || pop);
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({2'(g), m_sk[g]});
        for (int i = 0; i < NB; i++) begin
            fire = 1'b0;
            k    = EVT_PRESS;
            if (m_age[i] < 0) begin
                if (!m_btn_s[i]) begin
                    fire = 1'b1; k = EVT_PRESS; m_age[i] = 0;
                end
            end else if (m_btn_s[i]) begin
                fire = 1'b1; k = EVT_RELEASE; m_age[i] = -1;
            end else begin
                m_age[i]++;
                if (m_age[i] == HOLD) begin
                    fire = 1'b1; k = EVT_LONG;
                end else if (m_age[i] > HOLD && ((m_age[i] - HOLD) % REP) == 0) begin
                    fire = 1'b1; k = EVT_REPEAT;
                end
            end
            if (fire) begin
                if (m_sv[i] && !(push && g == i)) m_ovf = 1'b1;
                else begin
                    m_sv[i] = 1'b1; m_sk[i] = k;
                end
            end else if (push && g == i) begin
                m_sv[i] = 1'b0;
            end
        end
        m_btn_s = btns;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Runs on the falling edge: DUT outputs settled after the rising edge and
    // inputs (driven 2 ns after the rising edge) are those the next edge uses.
    logic [3:0] got_q [$];
    int         got_t [$];

    initial model_reset();

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) model_reset();
        if (rst_n && evt_valid && evt_ready) begin
            got_q.push_back({evt_btn, evt_kind});
            got_t.push_back(cyc);
        end
        chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (evt_valid && exp_q.size() > 0) chk("evt_head", 32'({evt_btn, evt_kind}), 32'(exp_q[0]));
        if (rst_n) model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_got();
        got_q.delete();
        got_t.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]      pat;
        int              len;
        int              n;
        logic [5:0][3:0] evs;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic [3:0] pat, input int len, input int n,
                           input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                           input logic [3:0] e3, input logic [3:0] e4, input logic [3:0] e5);
        vec_t v;
        v.pat = pat; v.len = len; v.n = n;
        v.evs[0] = e0; v.evs[1] = e1; v.evs[2] = e2;
        v.evs[3] = e3; v.evs[4] = e4; v.evs[5] = e5;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        clear_got();
        btns = v.pat;
        tick(v.len);
        btns = '1;
        tick(12);
        chk("vec_count", 32'(got_q.size()), 32'(v.n));
        for (int k = 0; k < v.n; k++) begin
            if (k < got_q.size()) chk("vec_event", 32'(got_q[k]), 32'(v.evs[k]));
        end
    endtask

    int t0;
    int stall;

    initial begin
        // len = cycles the pattern is held low at the sampling register
        add_vec(4'b1110,  3, 2, ev(0,EVT_PRESS), ev(0,EVT_RELEASE), 0, 0, 0, 0);
        add_vec(4'b0110,  3, 4, ev(0,EVT_PRESS), ev(3,EVT_PRESS), ev(0,EVT_RELEASE), ev(3,EVT_RELEASE), 0, 0);
        add_vec(4'b1011,  1, 2, ev(2,EVT_PRESS), ev(2,EVT_RELEASE), 0, 0, 0, 0);
        add_vec(4'b1101,  8, 2, ev(1,EVT_PRESS), ev(1,EVT_RELEASE), 0, 0, 0, 0);
        add_vec(4'b1101,  9, 3, ev(1,EVT_PRESS), ev(1,EVT_LONG), ev(1,EVT_RELEASE), 0, 0, 0);
        add_vec(4'b0111, 12, 3, ev(3,EVT_PRESS), ev(3,EVT_LONG), ev(3,EVT_RELEASE), 0, 0, 0);
        add_vec(4'b0111, 13, 4, ev(3,EVT_PRESS), ev(3,EVT_LONG), ev(3,EVT_REPEAT), ev(3,EVT_RELEASE), 0, 0);
        add_vec(4'b1011, 20, 5, ev(2,EVT_PRESS), ev(2,EVT_LONG), ev(2,EVT_REPEAT), ev(2,EVT_REPEAT), ev(2,EVT_RELEASE), 0);

        // reset state
        tick(3);
        chk("reset_valid", 32'(evt_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_btn", 32'(evt_btn), 32'd0);
        chk("reset_kind", 32'(evt_kind), 32'd0);
        rst_n = 1'b1;
        tick(2);

        foreach (vecs[i]) run_vec(vecs[i]);

        // press latency: valid seen on the 4th falling edge after driving,
        // i.e. after the third rising edge following the fall
        clear_got();
        t0 = cyc;
        btns = 4'b1110;
        tick(3);
        btns = '1;
        tick(10);
        if (got_t.size() > 0) chk("press_latency", 32'(got_t[0] - t0), 32'd4);
        else chk("press_latency_seen", 32'(got_t.size()), 32'd1);

        // simultaneous press: index 3 follows index 0 one cycle later
        clear_got();
        btns = 4'b0110;
        tick(3);
        btns = '1;
        tick(10);
        if (got_t.size() >= 2) chk("simul_gap", 32'(got_t[1] - got_t[0]), 32'd1);
        else chk("simul_seen", 32'(got_t.size()), 32'd4);

        // long press spacing
        clear_got();
        btns = 4'b1011;
        tick(20);
        btns = '1;
        tick(10);
        if (got_t.size() == 5) begin
            chk("long_spacing", 32'(got_t[1] - got_t[0]), 32'(HOLD));
            chk("repeat1_spacing", 32'(got_t[2] - got_t[1]), 32'(REP));
            chk("repeat2_spacing", 32'(got_t[3] - got_t[2]), 32'(REP));
        end else chk("long_events", 32'(got_t.size()), 32'd5);

        // backpressure: four fill the FIFO, the fifth waits, the sixth is dropped
        clear_got();
        evt_ready = 1'b0;
        btns = 4'b1110; tick(2);
        btns = 4'b1111; tick(2);
        btns = 4'b1110; tick(2);
        btns = 4'b1111; tick(2);
        btns = 4'b1110; tick(2);
        btns = 4'b1111; tick(3);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        tick(10);
        chk("bp_count", 32'(got_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size())
                chk("bp_order", 32'(got_q[k]), 32'(ev(0, (k % 2 == 0) ? EVT_PRESS : EVT_RELEASE)));
        end
        chk("bp_sticky", 32'(overflow), 32'd1);

        // reset while button 1 is in HELD
        btns = 4'b1101;
        tick(12);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_btn", 32'(evt_btn), 32'd0);
        chk("rst_kind", 32'(evt_kind), 32'd0);
        tick(2);
        rst_n = 1'b1;
        clear_got();
        tick(12);
        if (got_q.size() >= 2) begin
            chk("rst_press", 32'(got_q[0]), 32'(ev(1, EVT_PRESS)));
            chk("rst_long", 32'(got_q[1]), 32'(ev(1, EVT_LONG)));
            chk("rst_long_gap", 32'(got_t[1] - got_t[0]), 32'(HOLD));
        end else chk("rst_events", 32'(got_q.size()), 32'd2);
        btns = '1;
        tick(10);

        // randomized traffic against the model
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        stall = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 9) == 0) btns[i] = ~btns[i];
            end
            if (stall > 0) begin
                stall--;
                evt_ready = 1'b0;
            end else begin
                if ($urandom_range(0, 39) == 0) stall = $urandom_range(5, 15);
                evt_ready = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end
        btns = '1;
        evt_ready = 1'b1;
        tick(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
